// File: rtl/shift_defs.sv
// Shift mode and controller state encodings, shared with the ALU control decoder.
package shift_defs;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One iteration of the multi-cycle shifter: shift or rotate by k, where k <= STEP.
module shift_step
    import shift_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] out
);

    logic signed [WIDTH-1:0] in_s;
    logic        [WIDTH-1:0] rot;

    always_comb begin
        in_s = in;
        // Rotate via the low half of a doubled operand; correct for k == WIDTH as well.
        rot  = WIDTH'({in, in} >> k);
        out  = in;
        case (op)
            OP_SLL:  out = in << k;
            OP_SRL:  out = in >> k;
            OP_SRA:  out = in_s >>> k;
            default: out = rot;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR) moving at most STEP bits per clock
// under a start/busy/done handshake.
module iter_shifter
    import shift_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int KW = $clog2(STEP) + 1;

    state_t           state, state_nx;
    logic [1:0]       op_r;
    logic [SHW-1:0]   rem;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_out;

    // Bits moved this cycle: whatever remains, capped at STEP.
    always_comb begin
        if (int'(rem) < STEP) k = KW'(rem);
        else                  k = KW'(STEP);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .in  (dout),
        .op  (op_r),
        .k   (k),
        .out (step_out)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (shamt != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                busy = 1'b1;
                if (rem == SHW'(k)) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands are captured only at the accept edge; dout holds after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            rem  <= '0;
            op_r <= OP_SLL;
        end else if (state == IDLE && start) begin
            dout <= din;
            op_r <= op;
            rem  <= shamt;
        end else if (state == SHIFT) begin
            dout <= step_out;
            rem  <= rem - SHW'(k);
        end
    end

endmodule
